// File: rtl/s3g_tx_arb_pkg.sv
// s3g_tx_arb_pkg: payload sizes, FSM encoding and length saturation shared by the s3g_tx arbiter.
package s3g_tx_arb_pkg;

    localparam int S3G_MAX_PAYLOAD = 16;
    localparam int S3G_BUF_W       = 128;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} arb_state_t;

    function automatic logic [7:0] sat_len(input logic [7:0] len, input int unsigned max_len);
        return (32'(len) > max_len) ? 8'(max_len) : len;
    endfunction

endpackage

// File: rtl/s3g_tx_arb_rr_pick.sv
// s3g_tx_arb_rr_pick: pending mask + pointer -> one-hot winner, wrap-around search from ptr.
// With S3G_TX_ARB_PRIO_EN the lowest pending index wins and ptr is ignored.
module s3g_tx_arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

`ifdef S3G_TX_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // Scan from the farthest candidate down so the nearest pending index is written last.
    always_comb begin
        win = '0;
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
`ifdef S3G_TX_ARB_PRIO_EN
            j = IW'(k);
`else
            j = IW'((int'(ptr) + k) % N);
`endif
            if (pend[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/s3g_tx_arb.sv
// s3g_tx_arb: shares one s3g_tx framer between N_REQ sources, each with a one-deep slot.
// S3G_TX_ARB_PRIO_EN selects fixed lowest-index priority; otherwise round-robin.
module s3g_tx_arb import s3g_tx_arb_pkg::*; #(
    parameter int N_REQ    = 2,
    parameter int MAX_LEN  = S3G_MAX_PAYLOAD,
    parameter int BUSY_TMO = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_wr,
    input  logic [8*N_REQ-1:0]           req_len,
    input  logic [S3G_BUF_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]             req_busy,
    output logic [N_REQ-1:0]             req_done,
    output logic [N_REQ-1:0]             req_ovr,
    output logic [N_REQ-1:0]             grant,
    input  logic                         tx_busy,
    output logic                         tx_packet_wr,
    output logic [7:0]                   tx_payload_len,
    output logic [S3G_BUF_W-1:0]         tx_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    arb_state_t           state, state_nx;
    logic [7:0]           slot_len  [N_REQ];
    logic [S3G_BUF_W-1:0] slot_data [N_REQ];
    logic [IW-1:0]        ptr, win_idx, pick_idx;
    logic [N_REQ-1:0]     pend, pick_win;
    logic [TW-1:0]        tmo_cnt;
    logic                 done_evt;

    // The granted slot stays occupied but is no longer a candidate.
    assign pend         = req_busy & ~grant;
    assign tx_packet_wr = (state == LOAD);

    s3g_tx_arb_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .pend (pend),
        .ptr  (ptr),
        .win  (pick_win),
        .idx  (pick_idx)
    );

    always_comb begin
        state_nx = state;
        done_evt = 1'b0;
        case (state)
            IDLE:      state_nx = (|pend && !tx_busy) ? LOAD : IDLE;
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                done_evt = !tx_busy && (tmo_cnt == TW'(BUSY_TMO - 1));
                state_nx = tx_busy ? WAIT_DONE : done_evt ? IDLE : WAIT_BUSY;
            end
            WAIT_DONE: begin
                done_evt = !tx_busy;
                state_nx = tx_busy ? WAIT_DONE : IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= '0;
            win_idx        <= '0;
            tmo_cnt        <= '0;
            req_busy       <= '0;
            req_done       <= '0;
            req_ovr        <= '0;
            tx_payload_len <= '0;
            tx_data        <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slot_len[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            req_done <= '0;
            tmo_cnt  <= (state == WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
            if (state == IDLE && state_nx == LOAD) begin
                grant          <= pick_win;
                win_idx        <= pick_idx;
                tx_payload_len <= slot_len[pick_idx];
                tx_data        <= slot_data[pick_idx];
            end
            if (done_evt) begin
                grant             <= '0;
                req_done[win_idx] <= 1'b1;
                req_busy[win_idx] <= 1'b0;
            end
            // A slot freed on this edge still reads as busy here, so a write now overflows.
            for (int i = 0; i < N_REQ; i++) begin
                if (req_wr[i] && req_busy[i]) begin
                    req_ovr[i] <= 1'b1;
                end else if (req_wr[i]) begin
                    req_busy[i]  <= 1'b1;
                    slot_len[i]  <= sat_len(req_len[8*i +: 8], MAX_LEN);
                    slot_data[i] <= req_data[S3G_BUF_W*i +: S3G_BUF_W];
                end
            end
        end
    end

`ifdef S3G_TX_ARB_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (done_evt) begin
            ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_s3g_tx_arb.sv
// tb_s3g_tx_arb: directed scenarios plus randomized traffic against a per-source expected-frame model.
module tb_s3g_tx_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_wr;
    logic [15:0]  req_len;
    logic [255:0] req_data;
    logic [1:0]   req_busy, req_done, req_ovr, grant;
    logic         tx_busy;
    logic         tx_packet_wr;
    logic [7:0]   tx_payload_len;
    logic [127:0] tx_data;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    int bcnt;
    bit busy_en = 1'b1;

    s3g_tx_arb u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_wr         (req_wr),
        .req_len        (req_len),
        .req_data       (req_data),
        .req_busy       (req_busy),
        .req_done       (req_done),
        .req_ovr        (req_ovr),
        .grant          (grant),
        .tx_busy        (tx_busy),
        .tx_packet_wr   (tx_packet_wr),
        .tx_payload_len (tx_payload_len),
        .tx_data        (tx_data)
    );

    always #5 clk = ~clk;

    // s3g_tx stand-in: busy rises the cycle after the load strobe and stays high 40 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end else if (tx_packet_wr && busy_en) begin
            tx_busy <= 1'b1;
            bcnt    <= 40;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] exp_len(input logic [7:0] l);
        return (l > 8'd16) ? 8'd16 : l;
    endfunction

    // Source expected to win when both slots are pending.
    function automatic int both_first();
`ifdef S3G_TX_ARB_PRIO_EN
        return 0;
`else
        return m_ptr;
`endif
    endfunction

    task automatic stage(input int i, input logic [7:0] len, input logic [127:0] d);
        req_len[8*i +: 8]    = len;
        req_data[128*i +: 128] = d;
        req_wr[i]            = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        req_wr = '0;
    endtask

    task automatic wait_frame(input int budget, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < budget && !ok; c++) begin
            step();
            if (tx_packet_wr) begin
                ok = 1'b1;
                for (int k = 0; k < 2; k++) if (grant[k]) idx = k;
            end
        end
    endtask

    task automatic wait_done(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            step();
            if (req_done[i]) ok = 1'b1;
        end
        if (ok) m_ptr = (i + 1) % 2;
    endtask

    task automatic wait_busy(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            step();
            if (tx_busy === val) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_wr = '0;
        req_len = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        checks++; if ({req_busy, req_done, req_ovr, grant} !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", {req_busy, req_done, req_ovr, grant}); end
        checks++; if ({tx_packet_wr, tx_payload_len, tx_data} !== 137'd0) begin errors++; $display("FAIL reset_tx got wr=%b len=%0d data=%h exp all 0", tx_packet_wr, tx_payload_len, tx_data); end
        rst = 1'b0;
        m_ptr = 0;
        repeat (2) step();
        checks++; if ({req_busy, grant, tx_packet_wr} !== 5'd0) begin errors++; $display("FAIL reset_idle got busy=%b grant=%b wr=%b exp 0", req_busy, grant, tx_packet_wr); end
    endtask

    task automatic test_single();
        logic [127:0] d = '0;
        bit ok;
        d[23:0] = 24'h030201;
        stage(0, 8'd3, d);
        step();
        checks++; if (tx_packet_wr !== 1'b0 || req_busy !== 2'b01) begin errors++; $display("FAIL single_capture got wr=%b busy=%b exp wr=0 busy=01", tx_packet_wr, req_busy); end
        step();
        checks++; if (tx_packet_wr !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL single_latency got wr=%b grant=%b exp wr=1 grant=01", tx_packet_wr, grant); end
        checks++; if (tx_payload_len !== 8'd3 || tx_data[23:0] !== 24'h030201) begin errors++; $display("FAIL single_payload got len=%0d buf=%h exp len=3 buf=030201", tx_payload_len, tx_data[23:0]); end
        wait_busy(1'b1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_busy_rise got timeout exp tx_busy=1"); end
        wait_busy(1'b0, 60, ok);
        checks++; if (!ok || req_done !== 2'b00) begin errors++; $display("FAIL single_busy_fall got ok=%b done=%b exp ok=1 done=00", ok, req_done); end
        step();
        checks++; if (req_done !== 2'b01 || req_busy !== 2'b00 || grant !== 2'b00) begin errors++; $display("FAIL single_done got done=%b busy=%b grant=%b exp 01/00/00", req_done, req_busy, grant); end
        m_ptr = 1;
    endtask

    task automatic test_both();
        logic [127:0] d [2];
        int idx, first;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            d[0] = rnd128();
            d[1] = rnd128();
            first = both_first();
            stage(0, 8'd5, d[0]);
            stage(1, 8'd9, d[1]);
            step();
            wait_frame(10, idx, ok);
            checks++; if (!ok || idx != first || tx_data !== d[first]) begin errors++; $display("FAIL both_first_%0d got ok=%b idx=%0d exp idx=%0d", r, ok, idx, first); end
            wait_done(first, 60, ok);
            checks++; if (!ok) begin errors++; $display("FAIL both_done_first_%0d got timeout exp req_done[%0d]", r, first); end
            wait_frame(10, idx, ok);
            checks++; if (!ok || idx != 1 - first || tx_data !== d[1-first] || tx_payload_len !== (first ? 8'd5 : 8'd9)) begin errors++; $display("FAIL both_second_%0d got ok=%b idx=%0d len=%0d exp idx=%0d", r, ok, idx, tx_payload_len, 1 - first); end
            wait_done(1 - first, 60, ok);
            checks++; if (!ok) begin errors++; $display("FAIL both_done_second_%0d got timeout exp req_done[%0d]", r, 1 - first); end
        end
    endtask

    task automatic test_sat_zero();
        logic [127:0] d = rnd128();
        int idx;
        bit ok;
        stage(0, 8'd20, d);
        step();
        wait_frame(10, idx, ok);
        checks++; if (!ok || idx != 0 || tx_payload_len !== 8'd16 || tx_data !== d) begin errors++; $display("FAIL sat_len got ok=%b idx=%0d len=%0d exp idx=0 len=16", ok, idx, tx_payload_len); end
        wait_done(0, 60, ok);
        stage(0, 8'd0, d);
        step();
        wait_frame(10, idx, ok);
        checks++; if (!ok || tx_payload_len !== 8'd0) begin errors++; $display("FAIL zero_len got ok=%b len=%0d exp len=0", ok, tx_payload_len); end
        wait_done(0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done got timeout exp req_done[0]"); end
    endtask

    task automatic test_timeout();
        logic [127:0] d [2];
        int idx, first;
        bit ok;
        busy_en = 1'b0;
        d[0] = rnd128();
        d[1] = rnd128();
        first = both_first();
        stage(0, 8'd1, d[0]);
        stage(1, 8'd2, d[1]);
        step();
        wait_frame(10, idx, ok);
        checks++; if (!ok || idx != first) begin errors++; $display("FAIL tmo_first got ok=%b idx=%0d exp idx=%0d", ok, idx, first); end
        repeat (15) step();
        checks++; if (req_done !== 2'b00) begin errors++; $display("FAIL tmo_early got done=%b exp 00", req_done); end
        step();
        checks++; if (req_done[first] !== 1'b1 || req_busy[first] !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL tmo_done got done=%b busy=%b grant=%b exp slot %0d freed", req_done, req_busy, grant, first); end
        m_ptr = (first + 1) % 2;
        step();
        checks++; if (tx_packet_wr !== 1'b1 || grant[1-first] !== 1'b1 || tx_data !== d[1-first]) begin errors++; $display("FAIL tmo_next got wr=%b grant=%b exp wr=1 owner %0d", tx_packet_wr, grant, 1 - first); end
        wait_done(1 - first, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_next_done got timeout exp req_done[%0d]", 1 - first); end
        busy_en = 1'b1;
    endtask

    task automatic test_ovr();
        logic [127:0] x = rnd128();
        int idx, extra = 0;
        bit ok;
        stage(1, 8'd4, x);
        step();
        wait_frame(10, idx, ok);
        checks++; if (!ok || idx != 1) begin errors++; $display("FAIL ovr_frame got ok=%b idx=%0d exp idx=1", ok, idx); end
        repeat (3) step();
        stage(1, 8'd7, rnd128());
        step();
        checks++; if (req_ovr !== 2'b10 || req_busy[1] !== 1'b1) begin errors++; $display("FAIL ovr_set got ovr=%b busy=%b exp ovr=10 busy=1x", req_ovr, req_busy); end
        wait_done(1, 60, ok);
        checks++; if (!ok || req_ovr !== 2'b10) begin errors++; $display("FAIL ovr_sticky got ok=%b ovr=%b exp ovr=10", ok, req_ovr); end
        for (int c = 0; c < 10; c++) begin
            step();
            if (tx_packet_wr) extra++;
        end
        checks++; if (extra != 0 || tx_data !== x || tx_payload_len !== 8'd4 || req_busy !== 2'b00) begin errors++; $display("FAIL ovr_no_resend got extra=%0d len=%0d busy=%b exp 0 frames, len=4", extra, tx_payload_len, req_busy); end
    endtask

    task automatic test_reset_mid();
        int idx;
        bit ok;
        stage(1, 8'd5, rnd128());
        step();
        wait_frame(10, idx, ok);
        wait_busy(1'b1, 10, ok);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        checks++; if ({req_busy, req_done, req_ovr, grant, tx_packet_wr} !== 9'd0) begin errors++; $display("FAIL rstmid_flags got busy=%b ovr=%b grant=%b wr=%b exp 0", req_busy, req_ovr, grant, tx_packet_wr); end
        checks++; if (tx_payload_len !== 8'd0 || tx_data !== 128'd0) begin errors++; $display("FAIL rstmid_tx got len=%0d data=%h exp 0", tx_payload_len, tx_data); end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        step();
        stage(1, 8'd2, 128'h0000_0000_0000_0000_0000_0000_0000_beef);
        step();
        step();
        checks++; if (tx_packet_wr !== 1'b1 || grant !== 2'b10 || tx_payload_len !== 8'd2 || tx_data[15:0] !== 16'hbeef) begin errors++; $display("FAIL rstmid_after got wr=%b grant=%b len=%0d exp wr=1 grant=10 len=2", tx_packet_wr, grant, tx_payload_len); end
        wait_done(1, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done got timeout exp req_done[1]"); end
    endtask

    task automatic test_random();
        logic [7:0]   q_len  [2][$];
        logic [127:0] q_data [2][$];
        bit free [2] = '{1'b1, 1'b1};
        int issued = 0, frames = 0, idx;
        logic [7:0] l;
        logic [127:0] d;
        for (int c = 0; c < 4000 && (issued < 30 || !free[0] || !free[1]); c++) begin
            step();
            if (tx_packet_wr) begin
                idx = -1;
                for (int k = 0; k < 2; k++) if (grant[k]) idx = k;
                checks++;
                if (!$onehot(grant) || q_len[idx].size() == 0) begin
                    errors++; $display("FAIL rand_grant got grant=%b exp one-hot owner with a queued request", grant);
                end else begin
                    l = q_len[idx].pop_front();
                    d = q_data[idx].pop_front();
                    if (tx_payload_len !== l || tx_data !== d) begin errors++; $display("FAIL rand_frame src=%0d got len=%0d data=%h exp len=%0d data=%h", idx, tx_payload_len, tx_data, l, d); end
                end
                frames++;
                busy_en = ($urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_done[i]) begin
                    free[i] = 1'b1;
                    m_ptr = (i + 1) % 2;
                end
                if (free[i] && issued < 30 && $urandom_range(0, 3) == 0) begin
                    l = 8'($urandom_range(0, 24));
                    d = rnd128();
                    stage(i, l, d);
                    q_len[i].push_back(exp_len(l));
                    q_data[i].push_back(d);
                    free[i] = 1'b0;
                    issued++;
                end
            end
        end
        busy_en = 1'b1;
        checks++; if (frames != issued || issued != 30 || q_len[0].size() + q_len[1].size() != 0) begin errors++; $display("FAIL rand_drain got frames=%0d issued=%0d exp 30 sent", frames, issued); end
        checks++; if (req_ovr !== 2'b00 || req_busy !== 2'b00) begin errors++; $display("FAIL rand_end got ovr=%b busy=%b exp 00/00", req_ovr, req_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_sat_zero();
        test_timeout();
        test_ovr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion exp finish");
        $fatal(1, "watchdog");
    end

endmodule
